// File: rtl/sipo_deframer_pkg.sv
// Shared types and constants for the SIPO deframer and its PISO peer.
// Holds the FSM state encoding and the bit-counter width helper.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 10;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial receive bus plus parallel valid/ready word port of the deframer.
// slave = deframer side, master = PISO source and word consumer side.
interface sipo_deframer_if #(
  parameter int WIDTH = 10
);
  logic             si;
  logic             si_en;
  logic             sync;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             overrun;
  logic             sync_err;

  modport slave (
    input  si, si_en, sync, po_ready,
    output po, po_valid, overrun, sync_err
  );

  modport master (
    output si, si_en, sync, po_ready,
    input  po, po_valid, overrun, sync_err
  );
endinterface

// File: rtl/sipo_deframer_hold.sv
// Output holding register: loads a completed word the edge it arrives, result visible next cycle.
// A word arriving while full and not draining is dropped and flagged with a one-cycle OVERRUN.
module sipo_hold #(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_word_done,
  input  logic             i_po_ready,
  output logic [WIDTH-1:0] o_po,
  output logic             o_po_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_po;
  logic             r_vld;
  logic             r_ovr;
  logic             w_drain;
  logic             w_load;

  assign w_drain = r_vld & i_po_ready;
  assign w_load  = i_word_done & (~r_vld | i_po_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_po  <= '0;
      r_vld <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_ovr <= i_word_done & ~w_load;
      if (w_load) begin
        r_po  <= i_word;
        r_vld <= 1'b1;
      end else if (w_drain) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_po       = r_po;
  assign o_po_valid = r_vld;
  assign o_overrun  = r_ovr;

endmodule

// File: rtl/sipo_deframer.sv
// SYNC-framed MSB-first serial-to-parallel receiver; word visible the cycle after its last bit.
// Backpressure: one-word holding register; a further completed word while it is full is dropped.
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  sipo_deframer_if.slave  bus
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_sync_err, w_sync_err_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_word_done;
  logic [WIDTH-1:0] w_po;
  logic             w_po_valid;
  logic             w_overrun;

  assign w_word = {r_shreg[WIDTH-2:0], bus.si};

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shreg_nxt    = r_shreg;
    w_sync_err_nxt = 1'b0;
    w_word_done    = 1'b0;
    if (bus.si_en) begin
      if (bus.sync) begin
        // SYNC always wins, including on what would have been the completing bit
        w_sync_err_nxt = (r_state == SHIFT);
        w_state_nxt    = SHIFT;
        w_cnt_nxt      = CW'(1);
        w_shreg_nxt    = {{(WIDTH-1){1'b0}}, bus.si};
      end else if (r_state == SHIFT) begin
        w_shreg_nxt = w_word;
        if (r_cnt == LAST) begin
          w_word_done = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_sync_err <= w_sync_err_nxt;
    end
  end

  sipo_hold #(.WIDTH(WIDTH)) u_hold (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_word      (w_word),
    .i_word_done (w_word_done),
    .i_po_ready  (bus.po_ready),
    .o_po        (w_po),
    .o_po_valid  (w_po_valid),
    .o_overrun   (w_overrun)
  );

  assign bus.po       = w_po;
  assign bus.po_valid = w_po_valid;
  assign bus.overrun  = w_overrun;
  assign bus.sync_err = r_sync_err;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: directed word table, hand-written corner sequences and a random
// stream, all cross-checked every cycle against a queue-based framing model.
module tb_sipo_deframer;
  import sipo_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   seen_ovr;
  int   seen_serr;
  int   seen_vld;

  sipo_deframer_if #(.WIDTH(W)) bus ();

  sipo_deframer #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits collected since the last SYNC, plus a one-deep output slot.
  bit         m_bits[$];
  bit         m_in;
  logic [W-1:0] m_po;
  bit         m_vld;
  bit         m_ovr;
  bit         m_serr;

  task automatic model_reset();
    m_bits.delete();
    m_in   = 0;
    m_po   = '0;
    m_vld  = 0;
    m_ovr  = 0;
    m_serr = 0;
  endtask

  task automatic model_step(input bit en, input bit si, input bit sy, input bit rdy);
    bit           done;
    logic [W-1:0] word;
    done   = 0;
    word   = '0;
    m_ovr  = 0;
    m_serr = 0;
    if (en) begin
      if (sy) begin
        if (m_in) m_serr = 1;
        m_bits.delete();
        m_bits.push_back(si);
        m_in = 1;
      end else if (m_in) begin
        m_bits.push_back(si);
        if (m_bits.size() == W) begin
          foreach (m_bits[i]) word = (word << 1) | W'(m_bits[i]);
          done = 1;
          m_in = 0;
          m_bits.delete();
        end
      end
    end
    if (done) begin
      if (!m_vld || rdy) begin
        m_po  = word;
        m_vld = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, then compare all outputs with the model.
  task automatic cyc(input bit en, input bit si, input bit sy, input bit rdy);
    bus.si_en    = en;
    bus.si       = si;
    bus.sync     = sy;
    bus.po_ready = rdy;
    @(posedge clk);
    model_step(en, si, sy, rdy);
    #1;
    check("model {vld,ovr,serr,po}",
          32'({bus.po_valid, bus.overrun, bus.sync_err, bus.po}),
          32'({m_vld, m_ovr, m_serr, m_po}));
    seen_ovr  += int'(bus.overrun);
    seen_serr += int'(bus.sync_err);
    seen_vld  += int'(bus.po_valid);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gapped, input bit rdy, input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, w[W-1-i], i == 0, (i == W-1) ? rdy_last : rdy);
      if (gapped && i != W-1) cyc(1'b0, 1'($urandom), 1'($urandom), rdy);
    end
  endtask

  task automatic clear_seen();
    seen_ovr  = 0;
    seen_serr = 0;
    seen_vld  = 0;
  endtask

  task automatic do_reset();
    bus.si_en    = 1'b0;
    bus.si       = 1'b0;
    bus.sync     = 1'b0;
    bus.po_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check("reset outputs", 32'({bus.po_valid, bus.overrun, bus.sync_err, bus.po}), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] word;
    bit           gapped;
    logic [W-1:0] exp_po;
  } vec_t;

  vec_t vecs[5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_seen();
    rst_n = 1'b0;
    do_reset();

    vecs[0] = '{10'b1010100101, 1'b0, 10'h2A5};
    vecs[1] = '{10'b1010100101, 1'b1, 10'h2A5};
    vecs[2] = '{10'b1111111111, 1'b0, 10'h3FF};
    vecs[3] = '{10'b0000000001, 1'b1, 10'h001};
    vecs[4] = '{10'b1000000000, 1'b0, 10'h200};

    for (int v = 0; v < 5; v++) begin
      clear_seen();
      send_word(vecs[v].word, vecs[v].gapped, 1'b1, 1'b1);
      check($sformatf("vec%0d po", v), 32'(bus.po), 32'(vecs[v].exp_po));
      check($sformatf("vec%0d po_valid", v), 32'(bus.po_valid), 32'd1);
      check($sformatf("vec%0d flags", v), 32'(seen_ovr + seen_serr), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("vec%0d po_valid drop", v), 32'(bus.po_valid), 32'd0);
    end

    // Backpressure then overrun, then a single drain cycle.
    clear_seen();
    send_word(10'h155, 1'b0, 1'b0, 1'b0);
    send_word(10'h0AA, 1'b0, 1'b0, 1'b0);
    check("ovr pulse on 2nd completion", 32'(bus.overrun), 32'd1);
    check("ovr held po", 32'(bus.po), 32'h155);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr one-shot", 32'(bus.overrun), 32'd0);
    check("ovr count", 32'(seen_ovr), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("drain vld", 32'(bus.po_valid), 32'd0);
    check("drain po stable", 32'(bus.po), 32'h155);

    // Drain and load in the same edge.
    clear_seen();
    send_word(10'h155, 1'b0, 1'b0, 1'b0);
    send_word(10'h3FF, 1'b0, 1'b0, 1'b1);
    check("drain+load po", 32'(bus.po), 32'h3FF);
    check("drain+load vld", 32'(bus.po_valid), 32'd1);
    check("drain+load no ovr", 32'(seen_ovr), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Early SYNC after a 4-bit partial word.
    clear_seen();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i == 0, 1'b1);
    send_word(10'h001, 1'b0, 1'b1, 1'b1);
    check("resync serr count", 32'(seen_serr), 32'd1);
    check("resync po", 32'(bus.po), 32'h001);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word, then a clean word, then an unsynced stream.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, i == 0, 1'b1);
    do_reset();
    clear_seen();
    send_word(10'h2A5, 1'b0, 1'b1, 1'b1);
    check("post-reset po", 32'(bus.po), 32'h2A5);
    check("post-reset flags", 32'(seen_ovr + seen_serr), 32'd0);
    do_reset();
    clear_seen();
    for (int i = 0; i < 25; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b1);
    check("no sync no vld", 32'(seen_vld), 32'd0);

    // Random stream with phases of heavy backpressure.
    for (int i = 0; i < 4000; i++) begin
      bit hard;
      hard = ((i / 500) % 2) == 1;
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 11) == 0,
          hard ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0));
      if (i == 2500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
